// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its ALU result FIFO.
package wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_ALU_Q,
        SRC_ALU_BYP
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [ADDR_W-1:0] dest);
        return NUM_REGS'(1) << dest;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for queued ALU results; exposes every entry's destination
// and valid bit so the top can build the pending-destination mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  wb_req_t                       wdata_i,
    output wb_req_t                       head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [CNT_W-1:0]              count_o,
    output logic [DEPTH-1:0]              ent_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_dest_o
);

    wb_req_t           mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // NOTE: storage is left unreset on purpose; only pointers and count carry
    // meaning after reset, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] off;
        off         = '0;
        ent_valid_o = '0;
        ent_dest_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - rd_ptr_q;
            ent_valid_o[i] = (CNT_W'(off) < count_q);
            ent_dest_o[i]  = mem_q[i].dest;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: loads win, ALU results queue with a starvation guard.
// Optional build macro WB_R0_DISCARD_EN treats r0 as hardwired zero.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int ALU_Q_DEPTH  = 2,
    parameter  int STARVE_LIMIT = 4,
    localparam int CNT_W        = $clog2(ALU_Q_DEPTH) + 1,
    localparam int STV_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_dest,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                write_en,
    output logic [ADDR_W-1:0]   write_dest,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] pending_mask
);

    wb_req_t                            alu_req, mem_req, head, win;
    wb_src_e                            sel;
    logic                               fifo_full, fifo_empty, push, pop, force_alu, en_d;
    logic [CNT_W-1:0]                   fifo_count;
    logic [ALU_Q_DEPTH-1:0]             ent_valid;
    logic [ALU_Q_DEPTH-1:0][ADDR_W-1:0] ent_dest;
    logic [STV_W-1:0]                   starve_q, starve_d;
    logic                               write_en_q;
    logic [ADDR_W-1:0]                  write_dest_q;
    logic [DATA_W-1:0]                  write_data_q;

    assign alu_req = '{dest: alu_dest, data: alu_data};
    assign mem_req = '{dest: mem_dest, data: mem_data};

    wb_fifo #(.DEPTH(ALU_Q_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .wdata_i     (alu_req),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ent_valid_o (ent_valid),
        .ent_dest_o  (ent_dest)
    );

    // Readiness depends on registered state only, never on the valid inputs.
    assign force_alu = (starve_q == STV_W'(STARVE_LIMIT)) && !fifo_empty;
    assign alu_ready = !fifo_full;
    assign mem_ready = !force_alu;

    always_comb begin
        sel = SRC_NONE;
        win = head;
        if (force_alu) begin
            sel = SRC_ALU_Q;
        end else if (mem_valid) begin
            sel = SRC_MEM;
            win = mem_req;
        end else if (!fifo_empty) begin
            sel = SRC_ALU_Q;
        end else if (alu_valid) begin
            sel = SRC_ALU_BYP;
            win = alu_req;
        end
    end

    assign push = alu_valid && alu_ready && (sel != SRC_ALU_BYP);
    assign pop  = (sel == SRC_ALU_Q);

    always_comb begin
        starve_d = starve_q;
        if (sel == SRC_ALU_Q || sel == SRC_ALU_BYP) begin
            starve_d = '0;
        end else if (sel == SRC_MEM && !fifo_empty && starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

`ifdef WB_R0_DISCARD_EN
    // r0 writes still consume their arbitration slot but never strobe the file.
    assign en_d = (sel != SRC_NONE) && (win.dest != '0);
`else
    assign en_d = (sel != SRC_NONE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q     <= '0;
            write_en_q   <= 1'b0;
            write_dest_q <= '0;
            write_data_q <= '0;
        end else begin
            starve_q   <= starve_d;
            write_en_q <= en_d;
            if (sel != SRC_NONE) begin
                write_dest_q <= win.dest;
                write_data_q <= win.data;
            end
        end
    end

    assign write_en   = write_en_q;
    assign write_dest = write_dest_q;
    assign write_data = write_data_q;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < ALU_Q_DEPTH; i++) begin
            if (ent_valid[i]) pending_mask |= dest_onehot(ent_dest[i]);
        end
        if (write_en_q) pending_mask |= dest_onehot(write_dest_q);
`ifdef WB_R0_DISCARD_EN
        pending_mask[0] = 1'b0;
`endif
    end

    a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == CNT_W'(ALU_Q_DEPTH)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                alu_valid = 1'b0, mem_valid = 1'b0;
    logic [ADDR_W-1:0]   alu_dest = '0, mem_dest = '0;
    logic [DATA_W-1:0]   alu_data = '0, mem_data = '0;
    logic                alu_ready, mem_ready, write_en;
    logic [ADDR_W-1:0]   write_dest;
    logic [DATA_W-1:0]   write_data;
    logic [NUM_REGS-1:0] pending_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.ALU_Q_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_dest     (alu_dest),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_dest     (mem_dest),
        .mem_data     (mem_data),
        .write_en     (write_en),
        .write_dest   (write_dest),
        .write_data   (write_data),
        .pending_mask (pending_mask)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    wb_req_t           m_fifo[$];
    int                m_starve = 0;
    bit                m_last_en = 1'b0;
    logic [ADDR_W-1:0] m_last_dest = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every observed write against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (write_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_write", 32'(write_dest), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_cycle", 32'(cyc), 32'(e.cyc));
                        check("write_dest", 32'(write_dest), 32'(e.dest));
                        check("write_data", 32'(write_data), 32'(e.data));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    check("missing_write", 32'(write_en), 32'd1);
                end
            end
        end
    end

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_starve    = 0;
        m_last_en   = 1'b0;
        m_last_dest = '0;
    endtask

    // One clock of stimulus: drive, compare ready/mask, advance the model.
    task automatic step(input bit av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adt,
                        input bit mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdt,
                        output bit a_acc, output bit m_acc);
        bit            empty, full, frc, issued, alu_won, mem_won, bypass, en;
        logic [NUM_REGS-1:0] exp_mask;
        wb_req_t       w;
        @(negedge clk);
        alu_valid = av; alu_dest = ad; alu_data = adt;
        mem_valid = mv; mem_dest = md; mem_data = mdt;
        #1;
        empty = (m_fifo.size() == 0);
        full  = (m_fifo.size() == DEPTH);
        frc   = (m_starve == LIMIT) && !empty;
        check("alu_ready", 32'(alu_ready), 32'(!full));
        check("mem_ready", 32'(mem_ready), 32'(!frc));
        exp_mask = '0;
        foreach (m_fifo[i]) exp_mask[m_fifo[i].dest] = 1'b1;
        if (m_last_en) exp_mask[m_last_dest] = 1'b1;
`ifdef WB_R0_DISCARD_EN
        exp_mask[0] = 1'b0;
`endif
        check("pending_mask", 32'(pending_mask), 32'(exp_mask));

        a_acc = av && !full;
        m_acc = mv && !frc;
        issued = 1'b1; alu_won = 1'b0; mem_won = 1'b0; bypass = 1'b0;
        w = '0;
        if (frc) begin
            w = m_fifo.pop_front(); alu_won = 1'b1;
        end else if (mv) begin
            w = '{dest: md, data: mdt}; mem_won = 1'b1;
        end else if (!empty) begin
            w = m_fifo.pop_front(); alu_won = 1'b1;
        end else if (av) begin
            w = '{dest: ad, data: adt}; alu_won = 1'b1; bypass = 1'b1;
        end else begin
            issued = 1'b0;
        end
        if (a_acc && !bypass) m_fifo.push_back('{dest: ad, data: adt});
        if (alu_won) m_starve = 0;
        else if (mem_won && !empty && m_starve < LIMIT) m_starve++;
        en = issued;
`ifdef WB_R0_DISCARD_EN
        if (w.dest == '0) en = 1'b0;
`endif
        if (en) exp_q.push_back('{cyc: cyc + 1, dest: w.dest, data: w.data});
        m_last_en = en;
        if (issued) m_last_dest = w.dest;
    endtask

    task automatic idle(input int n);
        bit aa, ma;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, aa, ma);
    endtask

    initial begin
        bit aa, ma, ap, mp;
        int alu_n, mem_k;
        logic [ADDR_W-1:0] rad, rmd;
        logic [DATA_W-1:0] radt, rmdt;

        #1;
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_pending", 32'(pending_mask), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Bypass on an idle cycle.
        step(1'b1, 3'd3, 16'h00A5, 1'b0, '0, '0, aa, ma);
        idle(2);

        // Collision: load first, queued ALU result next.
        step(1'b1, 3'd5, 16'h2222, 1'b1, 3'd2, 16'h1111, aa, ma);
        idle(3);

        // Starvation and full-FIFO back-pressure with loads held continuously.
        alu_n = 0; mem_k = 0;
        for (int n = 0; n < 24; n++) begin
            step(alu_n < 3, 3'(4 + alu_n), 16'hA000 + 16'(alu_n),
                 1'b1, 3'(mem_k), 16'h5000 + 16'(mem_k), aa, ma);
            if (aa) alu_n++;
            if (ma) mem_k++;
        end
        idle(4);

        // Mid-operation reset with two queued ALU results.
        step(1'b1, 3'd6, 16'hC001, 1'b1, 3'd1, 16'hD001, aa, ma);
        step(1'b1, 3'd7, 16'hC002, 1'b1, 3'd2, 16'hD002, aa, ma);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_write_en", 32'(write_en), 32'd0);
        check("midrst_pending", 32'(pending_mask), 32'd0);
        check("midrst_alu_ready", 32'(alu_ready), 32'd1);
        check("midrst_mem_ready", 32'(mem_ready), 32'd1);
        alu_valid = 1'b0; mem_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Load to r0: normal register, or discarded when r0 is hardwired.
        step(1'b0, '0, '0, 1'b1, 3'd0, 16'hBEEF, aa, ma);
        check("r0_mem_accepted", 32'(ma), 32'd1);
        idle(2);

        // Randomized traffic: heavy loads first, then lighter.
        ap = 1'b0; mp = 1'b0;
        rad = '0; rmd = '0; radt = '0; rmdt = '0;
        for (int n = 0; n < 400; n++) begin
            if (!ap && $urandom_range(0, 99) < 55) begin
                ap = 1'b1; rad = 3'($urandom); radt = 16'($urandom);
            end
            if (!mp && $urandom_range(0, 99) < ((n < 200) ? 85 : 30)) begin
                mp = 1'b1; rmd = 3'($urandom); rmdt = 16'($urandom);
            end
            step(ap, rad, radt, mp, rmd, rmdt, aa, ma);
            if (aa) ap = 1'b0;
            if (ma) mp = 1'b0;
        end
        idle(8);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 8x16 general-purpose register file.
- Merges two result producers into the register file's single write port: an ALU result stream and a memory-load result stream.
- Load results have priority. ALU results wait in a small FIFO, with a starvation guard so they are never held off indefinitely.
- Publishes a pending-destination mask for the hazard logic.

Parameters:
- DATA_W, 16, result/register data width
- ADDR_W, 3, register index width (8 registers)
- ALU_Q_DEPTH, 2, ALU result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before ALU is forced to win

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when high with mem_valid
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- write_en  out  1  register file write strobe (registered)
- write_dest  out  ADDR_W  register file write index (registered)
- write_data  out  DATA_W  register file write data (registered)
- pending_mask  out  8  bit i set if register i has a queued or in-flight write

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously clears the following: write_en, write_dest, write_data, FIFO pointers and count, starve_cnt and pending_mask, all to 0.
  - Reset mid-operation discards queued ALU results without writing them.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - Valid must hold, with stable payload, until accepted.
  - alu_ready = !fifo_full.
  - mem_ready = !force_alu, where force_alu = (starve_cnt == STARVE_LIMIT) && !fifo_empty.
  - Both ready outputs are combinational from state only, never from the valid inputs.
  - After reset both are 1.
- Arbitration, evaluated each cycle; the winner is loaded into the output register on the edge:
  1. force_alu: FIFO head issues.
  2. Otherwise mem_valid: the load issues.
  3. Otherwise FIFO non-empty: FIFO head issues.
  4. Otherwise alu_valid with FIFO empty: bypass, the ALU input issues directly and is not enqueued.
  5. Otherwise write_en = 0 next cycle, and dest/data hold their previous values.
- ALU acceptance:
  - An accepted ALU result that does not issue (cases 1-3 active, or bypass not taken) is enqueued.
  - When FIFO is full, alu_ready = 0 even if a dequeue happens that cycle.
  - Simultaneous enqueue and dequeue when not full is legal; the count is unchanged.
  - FIFO order is strict; pointers wrap modulo ALU_Q_DEPTH.
- Latency:
  - Load or bypassed ALU result: write_en is high in the cycle after the accepting edge.
  - Queued ALU result: issues no earlier than the cycle after enqueue.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each edge where FIFO is non-empty and the load wins.
  - Clears on any ALU issue.
  - Holds otherwise.
- pending_mask:
  - OR of the one-hot dests of all valid FIFO entries, plus one-hot(write_dest) when write_en.
  - Combinational from registered state.
- Ordering:
  - No WAW resolution between the two sources; the issuing pipeline uses pending_mask to stall.
  - Same-source ordering is preserved.
- Output register content:
  - write_dest and write_data exactly equal the winning payload.
  - No arithmetic or width change.

Optional Feature:
- Macro: WB_R0_DISCARD_EN.
- Defined: r0 is hardwired zero.
  - Results with dest == 0 are accepted and issued normally (arbitration, FIFO and starvation unchanged), but write_en is forced 0 for that slot.
  - Bit 0 of pending_mask is always 0.
- Undefined: r0 is an ordinary register and is written normally.

Decomposition:
- Shared package wb_pkg holds:
  - DATA_W and ADDR_W constants
  - typedef wb_req_t {dest, data}
  - enum wb_src_e {SRC_NONE, SRC_MEM, SRC_ALU_Q, SRC_ALU_BYP} for the arbitration select
- One sub-module: wb_fifo, a parameterised synchronous FIFO with full/empty/count outputs and per-entry dest visibility for pending_mask.
- Arbiter, starvation counter and output register live in wb_arbiter.

Test Plan:
- Reset then idle: after rst_n is released, check write_en=0, pending_mask=0, alu_ready=1, mem_ready=1.
- Bypass: alu_valid with dest=3, data=0x00A5 on an idle cycle -> next cycle write_en=1, write_dest=3, write_data=0x00A5; FIFO stays empty.
- Collision: same cycle mem (dest=2, data=0x1111) and alu (dest=5, data=0x2222):
  - cycle+1 writes r2=0x1111;
  - cycle+2 writes r5=0x2222;
  - pending_mask bit5 is set in cycle+1.
- Starvation: fill the FIFO with 2 ALU results, then hold mem_valid continuously:
  - exactly 4 load writes;
  - then mem_ready=0 for one cycle while ALU entry 0 writes;
  - pattern repeats for entry 1.
- Full FIFO: 2 queued entries with mem_valid held -> alu_ready=0; a third ALU result is accepted only after a dequeue.
- Mid-operation reset: assert rst_n low with 2 queued entries -> write_en drops immediately with no clock; after release, no stale writes occur.
- If WB_R0_DISCARD_EN is defined: load to dest=0 -> accepted, write_en stays 0.
